// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with a valid/ready handshake, a two-entry skid buffer,
// synchronous flush and optional zeroing of out_data while the stage is empty.
module pipe_stage_buf #(
  parameter int WIDTH       = 32,
  parameter bit BUBBLE_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       occupancy
);

  // The encoding doubles as the occupancy count; bit 1 alone marks FULL.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] skid_data;
  logic             accept;
  logic             pop;
  logic             load_main_in;
  logic             load_main_skid;
  logic             load_skid;

  assign in_ready  = ~state[1];
  assign out_valid = (state != EMPTY);
  assign occupancy = state;
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_next   = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && pop) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_next = FULL;
            load_skid  = 1'b1;
          end else if (pop) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_next     = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) state <= EMPTY;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the payload registers are reset too, so out_data reads 0 after reset in both bubble modes.
    if (!rst) begin
      main_data <= '0;
      skid_data <= '0;
    end else begin
      if (load_main_in)        main_data <= in_data;
      else if (load_main_skid) main_data <= skid_data;
      if (load_skid)           skid_data <= in_data;
    end
  end

  generate
    if (BUBBLE_ZERO) begin : g_bubble_zero
      assign out_data = out_valid ? main_data : '0;
    end else begin : g_bubble_hold
      assign out_data = main_data;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: directed scenarios plus a randomized run
// against a queue model of the stage, with zeroing, holding and 8-bit instances.
module tb_pipe_stage_buf;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        flush;

  logic        in_ready_z,  out_valid_z;
  logic [31:0] out_data_z;
  logic [1:0]  occupancy_z;
  logic        in_ready_h,  out_valid_h;
  logic [31:0] out_data_h;
  logic [1:0]  occupancy_h;
  logic        in_ready_8,  out_valid_8;
  logic [7:0]  out_data_8;
  logic [1:0]  occupancy_8;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: the held entries in FIFO order plus the last front value.
  logic [31:0] q[$];
  logic [31:0] hold_val;
  bit          last_acc;

  pipe_stage_buf #(.WIDTH(32), .BUBBLE_ZERO(1'b1)) dut_z (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_z), .in_data(in_data),
    .out_valid(out_valid_z), .out_ready(out_ready), .out_data(out_data_z), .flush(flush),
    .occupancy(occupancy_z));

  pipe_stage_buf #(.WIDTH(32), .BUBBLE_ZERO(1'b0)) dut_h (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_h), .in_data(in_data),
    .out_valid(out_valid_h), .out_ready(out_ready), .out_data(out_data_h), .flush(flush),
    .occupancy(occupancy_h));

  pipe_stage_buf #(.WIDTH(8), .BUBBLE_ZERO(1'b1)) dut_8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_8), .in_data(in_data[7:0]),
    .out_valid(out_valid_8), .out_ready(out_ready), .out_data(out_data_8), .flush(flush),
    .occupancy(occupancy_8));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Upstream protocol: a stalled payload must stay put until accepted.
  logic        prev_valid, prev_ready;
  logic [31:0] prev_data;
  always @(posedge clk) begin
    if (rst && prev_valid && !prev_ready && in_valid)
      assert (in_data == prev_data) else $error("in_data changed while stalled");
    prev_valid <= in_valid;
    prev_ready <= in_ready_z;
    prev_data  <= in_data;
  end

  // Advance one clock edge and apply the stage rules to the model.
  task automatic tick();
    bit acc, pp;
    @(posedge clk);
    acc = in_valid && (q.size() < 2);
    pp  = (q.size() > 0) && out_ready;
    if (flush) begin
      q.delete();
    end else begin
      if (pp)  void'(q.pop_front());
      if (acc) q.push_back(in_data);
    end
    if (q.size() > 0) hold_val = q[0];
    last_acc = acc;
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
  endtask

  task automatic test_reset();
    #2;
    total_cnt++; if (out_valid_z !== 1'b0) $display("FAIL reset_valid got %0b want 0", out_valid_z); else pass_cnt++;
    total_cnt++; if (occupancy_z !== 2'd0) $display("FAIL reset_occ got %0d want 0", occupancy_z); else pass_cnt++;
    total_cnt++; if (in_ready_z !== 1'b1) $display("FAIL reset_ready got %0b want 1", in_ready_z); else pass_cnt++;
    total_cnt++; if (out_data_z !== 32'h0) $display("FAIL reset_data_z got %h want 0", out_data_z); else pass_cnt++;
    total_cnt++; if (out_data_h !== 32'h0) $display("FAIL reset_data_h got %h want 0", out_data_h); else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_streaming();
    logic [31:0] vals [3];
    vals = '{32'h11, 32'h22, 32'h33};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, vals[i], 1'b1, 1'b0);
      tick();
      total_cnt++; if (out_data_z !== vals[i]) $display("FAIL stream_data got %h want %h", out_data_z, vals[i]); else pass_cnt++;
      total_cnt++; if (occupancy_z !== 2'd1) $display("FAIL stream_occ got %0d want 1", occupancy_z); else pass_cnt++;
      total_cnt++; if (in_ready_z !== 1'b1) $display("FAIL stream_ready got %0b want 1", in_ready_z); else pass_cnt++;
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    total_cnt++; if (occupancy_z !== 2'd0) $display("FAIL stream_drain_occ got %0d want 0", occupancy_z); else pass_cnt++;
    total_cnt++; if (out_data_z !== 32'h0) $display("FAIL stream_drain_data got %h want 0", out_data_z); else pass_cnt++;
  endtask

  task automatic test_stall_fill();
    drive(1'b1, 32'hA, 1'b0, 1'b0); tick();
    drive(1'b1, 32'hB, 1'b0, 1'b0); tick();
    total_cnt++; if (occupancy_z !== 2'd2) $display("FAIL fill_occ got %0d want 2", occupancy_z); else pass_cnt++;
    total_cnt++; if (in_ready_z !== 1'b0) $display("FAIL fill_ready got %0b want 0", in_ready_z); else pass_cnt++;
    total_cnt++; if (out_data_z !== 32'hA) $display("FAIL fill_front got %h want a", out_data_z); else pass_cnt++;
    drive(1'b1, 32'hC, 1'b0, 1'b0); tick();
    total_cnt++; if (occupancy_z !== 2'd2) $display("FAIL fill_hold_occ got %0d want 2", occupancy_z); else pass_cnt++;
    drive(1'b1, 32'hC, 1'b1, 1'b0); tick();
    total_cnt++; if (out_data_z !== 32'hB) $display("FAIL fill_pop1 got %h want b", out_data_z); else pass_cnt++;
    total_cnt++; if (occupancy_z !== 2'd1) $display("FAIL fill_pop1_occ got %0d want 1", occupancy_z); else pass_cnt++;
    total_cnt++; if (in_ready_z !== 1'b1) $display("FAIL fill_pop1_ready got %0b want 1", in_ready_z); else pass_cnt++;
    tick();
    total_cnt++; if (out_data_z !== 32'hC) $display("FAIL fill_third got %h want c", out_data_z); else pass_cnt++;
    drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
    total_cnt++; if (out_valid_z !== 1'b0) $display("FAIL fill_empty got %0b want 0", out_valid_z); else pass_cnt++;
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h5, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h6, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h7, 1'b0, 1'b1); tick();
    total_cnt++; if (out_valid_z !== 1'b0) $display("FAIL flush_valid got %0b want 0", out_valid_z); else pass_cnt++;
    total_cnt++; if (out_data_z !== 32'h0) $display("FAIL flush_data got %h want 0", out_data_z); else pass_cnt++;
    total_cnt++; if (occupancy_z !== 2'd0) $display("FAIL flush_occ got %0d want 0", occupancy_z); else pass_cnt++;
    total_cnt++; if (in_ready_z !== 1'b1) $display("FAIL flush_ready got %0b want 1", in_ready_z); else pass_cnt++;
    drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
    total_cnt++; if (out_valid_z !== 1'b0) $display("FAIL flush_no7 got %0b want 0", out_valid_z); else pass_cnt++;
    drive(1'b1, 32'h9, 1'b0, 1'b0); tick();
    drive(1'b1, 32'hA5, 1'b1, 1'b1); tick();
    total_cnt++; if (occupancy_z !== 2'd0) $display("FAIL flush_one_occ got %0d want 0", occupancy_z); else pass_cnt++;
    drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
    total_cnt++; if (out_valid_z !== 1'b0) $display("FAIL flush_accept_dropped got %0b want 0", out_valid_z); else pass_cnt++;
  endtask

  task automatic test_bubble();
    drive(1'b1, 32'hDEADBEEF, 1'b1, 1'b0); tick();
    total_cnt++; if (out_data_h !== 32'hDEADBEEF) $display("FAIL bubble_load got %h want deadbeef", out_data_h); else pass_cnt++;
    drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
    total_cnt++; if (out_data_z !== 32'h0) $display("FAIL bubble_zero got %h want 0", out_data_z); else pass_cnt++;
    total_cnt++; if (out_data_h !== 32'hDEADBEEF) $display("FAIL bubble_hold got %h want deadbeef", out_data_h); else pass_cnt++;
    total_cnt++; if (out_valid_h !== 1'b0) $display("FAIL bubble_hold_valid got %0b want 0", out_valid_h); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'h21, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h22, 1'b0, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    total_cnt++; if (occupancy_z !== 2'd2) $display("FAIL areset_pre_occ got %0d want 2", occupancy_z); else pass_cnt++;
    #2 rst = 1'b0;
    #1;
    total_cnt++; if (out_valid_z !== 1'b0) $display("FAIL areset_valid got %0b want 0", out_valid_z); else pass_cnt++;
    total_cnt++; if (occupancy_z !== 2'd0) $display("FAIL areset_occ got %0d want 0", occupancy_z); else pass_cnt++;
    total_cnt++; if (in_ready_z !== 1'b1) $display("FAIL areset_ready got %0b want 1", in_ready_z); else pass_cnt++;
    total_cnt++; if (out_data_h !== 32'h0) $display("FAIL areset_data_h got %h want 0", out_data_h); else pass_cnt++;
    q.delete();
    hold_val = '0;
    last_acc = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 32'h1, 1'b1, 1'b0); tick();
    total_cnt++; if (out_data_z !== 32'h1) $display("FAIL areset_push got %h want 1", out_data_z); else pass_cnt++;
    total_cnt++; if (occupancy_z !== 2'd1) $display("FAIL areset_push_occ got %0d want 1", occupancy_z); else pass_cnt++;
    drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
  endtask

  task automatic test_random();
    logic [31:0] exp_front;
    for (int n = 0; n < 10000; n++) begin
      if (!in_valid || last_acc) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = $urandom;
      end
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 99) < 2);
      tick();
      exp_front = (q.size() > 0) ? q[0] : 32'h0;
      total_cnt++; if (out_valid_8 !== (q.size() > 0)) $display("FAIL rand_valid cyc %0d got %0b want %0b", n, out_valid_8, q.size() > 0); else pass_cnt++;
      total_cnt++; if (occupancy_8 !== 2'(q.size())) $display("FAIL rand_occ cyc %0d got %0d want %0d", n, occupancy_8, q.size()); else pass_cnt++;
      total_cnt++; if (in_ready_8 !== (q.size() < 2)) $display("FAIL rand_ready cyc %0d got %0b want %0b", n, in_ready_8, q.size() < 2); else pass_cnt++;
      total_cnt++; if (out_data_8 !== exp_front[7:0]) $display("FAIL rand_data8 cyc %0d got %h want %h", n, out_data_8, exp_front[7:0]); else pass_cnt++;
      total_cnt++; if (out_data_z !== exp_front) $display("FAIL rand_data_z cyc %0d got %h want %h", n, out_data_z, exp_front); else pass_cnt++;
      total_cnt++; if (out_data_h !== hold_val) $display("FAIL rand_data_h cyc %0d got %h want %h", n, out_data_h, hold_val); else pass_cnt++;
    end
  endtask

  initial begin
    rst       = 1'b0;
    hold_val  = '0;
    last_acc  = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    test_reset();
    test_streaming();
    test_stall_fill();
    test_flush();
    test_bubble();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised pipeline stage register: the next generation of the fixed fd/dx/xm stage registers.
- Adds a valid/ready handshake, backpressure (stall), synchronous flush and bubble insertion.
- Two-entry skid buffer, so in_ready is a registered signal and never combinationally depends on out_ready.
- Instantiated between any two CPU stages; the payload is the concatenated stage signals, of any width.

Parameters:
- WIDTH, 32, payload width in bits (1..256).
- BUBBLE_ZERO, 1, 1: out_data is forced to 0 (MIPS nop) whenever out_valid=0. 0: out_data holds its last value when empty.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low; all state cleared while rst=0
- in_valid  input  1  upstream stage presents in_data
- in_ready  output  1  stage can accept this cycle
- in_data  input  WIDTH  upstream payload
- out_valid  output  1  out_data holds a valid entry
- out_ready  input  1  downstream accepts (0 = stall)
- out_data  output  WIDTH  payload to downstream stage
- flush  input  1  synchronous squash of all held entries (branch taken)
- occupancy  output  2  entries held: 0, 1 or 2

Behaviour:
- Storage: main register (drives out_data) and skid register, each with its own valid bit.
- States: EMPTY (none valid), ONE (main valid), FULL (main and skid valid). occupancy = 0/1/2.
- in_ready = !skid_valid, taken directly from a flop; 1 in EMPTY and ONE, 0 in FULL.
- Accept = in_valid & in_ready at a rising edge. Pop = out_valid & out_ready at a rising edge.
- EMPTY: accept -> ONE, main <= in_data.
- ONE, accept & pop -> ONE, main <= in_data.
- ONE, accept & !pop -> FULL, skid <= in_data.
- ONE, !accept & pop -> EMPTY.
- ONE, neither -> hold.
- FULL: no accept is possible. Pop -> ONE, main <= skid. No pop -> hold.
- Ordering is strictly FIFO. No entry is ever dropped or duplicated except by flush.
- Latency in_data -> out_data is 1 cycle. Throughput is 1 entry/cycle while out_ready=1.
- flush=1 at an edge has the highest priority:
  - next state EMPTY;
  - a same-cycle accept is discarded;
  - a same-cycle pop still counts as completed downstream;
  - in_ready is 1 in the following cycle.
- With BUBBLE_ZERO=1, out_data=0 in every cycle with out_valid=0, including after flush and after reset.
- With BUBBLE_ZERO=0, out_data holds its last value when out_valid=0.
- Reset values, applied asynchronously when rst falls:
  - out_valid=0, occupancy=0, in_ready=1, out_data=0;
  - main and skid data registers = 0.
- Reset mid-operation: held entries are lost. The first accept after rst rises starts from EMPTY.
- Upstream must hold in_data stable while in_valid=1 and in_ready=0. Behaviour on violation is undefined. The bench checks it with an assertion.
- out_data/out_valid change only on clk edges or on asynchronous reset.

Test Plan:
- Streaming: WIDTH=32, out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 one cycle later each; occupancy stays 1; in_ready stays 1.
- Stall fill: push 0xA then 0xB with out_ready=0 -> occupancy 2, in_ready=0. Then out_ready=1 -> pops 0xA then 0xB, back to EMPTY; a third in_valid held during FULL is accepted only after in_ready returns to 1.
- Flush with simultaneous push: FULL holding 0x5,0x6, flush=1 with in_valid=1, in_data=0x7 -> next cycle out_valid=0, out_data=0, occupancy=0; 0x7 never appears.
- Bubble modes: BUBBLE_ZERO=1, pop last entry 0xDEADBEEF -> out_data=0 next cycle. BUBBLE_ZERO=0, same stimulus -> out_data stays 0xDEADBEEF with out_valid=0.
- Async reset: drop rst mid-cycle in FULL -> out_valid=0, occupancy=0, in_ready=1 immediately without a clk edge; after release, push 0x1 -> appears after 1 cycle.
- Random: 10k cycles of random in_valid/out_ready/flush (flush 2%) with WIDTH=8 against a reference queue model -> order matches exactly and no loss except flushed entries.
